// File: rtl/ula_pkg.sv
// Shared op encodings and FSM state enumeration for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH busy cycles after start; done is high in the last busy cycle with product valid.
// Backpressure: none; start is only honoured by the caller when the unit is idle.
module ula_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] step_acc;

  // Product exposed is the accumulator including the current step, so the
  // final partial product is visible in the same cycle done is raised.
  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = step_acc;
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);

  // Next-state: load on start, otherwise one shift-add step per busy cycle;
  // the counter stops at LAST and never wraps.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle ops plus iterative MUL, registered result and flags.
// Latency: 1 cycle accept->out_valid for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: one op in flight; in_ready low until the result is taken (out_valid & out_ready).
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SHAMT_LIMIT = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

  // Multiplier captures its operands on the accept edge, so later operand
  // changes cannot disturb it.
  assign mul_start = (state_q == ST_IDLE) && in_valid && (op == OP_MUL);

  ula_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_start),
    .a      (in0),
    .b      (in1),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath for every op except MUL; only sampled on accept.
  always_comb begin
    add_full  = {1'b0, in0} + {1'b0, in1};
    sub_res   = in0 - in1;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (in0[WIDTH-1] == in1[WIDTH-1]) && (add_full[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_res;
        alu_carry = (in0 < in1);
        alu_ovf   = (in0[WIDTH-1] != in1[WIDTH-1]) && (sub_res[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SLL:  alu_res = (in1 >= SHAMT_LIMIT) ? '0 : (in0 << in1);
      OP_SRL:  alu_res = (in1 >= SHAMT_LIMIT) ? '0 : (in0 >> in1);
      OP_OR:   alu_res = in0 | in1;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      OP_AND:  alu_res = in0 & in1;
      default: alu_res = '0;
    endcase
  end

  // FSM next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d     = ST_DONE;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          result_d    = mul_product[WIDTH-1:0];
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          carry_d     = 1'b0;
          ovf_d       = |mul_product[2*WIDTH-1:WIDTH];
          out_valid_d = 1'b1;
        end else if (!mul_busy) begin
          // Multiplier idle while we wait on it cannot happen in normal
          // operation; fall back to IDLE rather than hang.
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // FSM and registered outputs; reset overrides any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (WIDTH=16): directed vectors with hand-computed results.
// Expected results are queued at accept; a monitor pops and compares on out_valid.
// Covers latency, flags, shift limits, backpressure hold, MUL abort by reset.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    int           lat;
    int           acc;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  ula_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in0      (in0),
    .in1      (in1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one op; when accepted, optionally queue its expected response.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic z, input logic c, input logic v,
                       input int lat, input bit push);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clock); #1;
    op = o; in0 = a; in1 = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        if (push) begin
          e.res = r; e.z = z; e.c = c; e.o = v; e.lat = lat; e.acc = cyc;
          sb.push_back(e);
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never seen for op %0d", o);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in0 = ~a;
    in1 = ~b;
    op  = o ^ 3'b101;
  endtask

  // Wait until all queued results have been delivered and the DUT is idle.
  task automatic wait_idle();
    bool_loop: for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && in_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d results outstanding", sb.size());
  endtask

  // Monitor: compare on first out_valid, then check hold while stalled.
  initial begin
    exp_t cur;
    bit   pending;
    bit   have;
    pending = 1'b0;
    have    = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pending = 1'b0;
      end else if (out_valid) begin
        if (!pending) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            have = 1'b0;
            $display("FAIL unexpected_output: result 0x%0h with no op outstanding", result);
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk("result",  32'(result), 32'(cur.res));
            chk("zero",    32'(zero),   32'(cur.z));
            chk("carry",   32'(carry),  32'(cur.c));
            chk("ovf",     32'(ovf),    32'(cur.o));
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
          pending = 1'b1;
        end else if (have) begin
          chk("hold_result",   32'(result),   32'(cur.res));
          chk("hold_flags",    {29'd0, zero, carry, ovf}, {29'd0, cur.z, cur.c, cur.o});
          chk("in_ready_done", 32'(in_ready), 32'd0);
        end
        if (out_ready) pending = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = OP_ADD; in0 = '0; in1 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_flags",     {29'd0, zero, carry, ovf}, 32'd0);

    //     op      in0       in1       result    z     c     o    lat
    issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1, 1'b1); wait_idle();
    issue(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1, 1'b1); wait_idle();
    issue(OP_SLT, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SLT, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SLL, 16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SLL, 16'h0001, 16'd16,   16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SLL, 16'h00FF, 16'd4,    16'h0FF0, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SRL, 16'h8000, 16'd4,    16'h0800, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_SRL, 16'h8000, 16'd20,   16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_OR,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1, 1'b1); wait_idle();

    // MUL, with a stray offer during the iteration that must be ignored.
    issue(OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17, 1'b1);
    in_valid = 1'b1; op = OP_ADD; in0 = 16'h1111; in1 = 16'h2222;
    repeat (5) @(posedge clock);
    #1 in_valid = 1'b0;
    wait_idle();
    issue(OP_MUL, 16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 17, 1'b1); wait_idle();

    // Backpressure: hold DONE for 5 cycles while offering another op.
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    in_valid = 1'b1; op = OP_OR; in0 = 16'hAAAA; in1 = 16'h5555;
    repeat (4) @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    wait_idle();

    // Reset in MUL cycle 8 aborts the multiply; no result may appear.
    issue(OP_MUL, 16'h1234, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 17, 1'b0);
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result",    32'(result),    32'd0);
    chk("abort_flags",     {29'd0, zero, carry, ovf}, 32'd0);
    issue(OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    wait_idle();

    repeat (25) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; legal range 4..32.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  operand/op offer from producer.
REQ-005 in_ready  out  1  block can accept an operation.
REQ-006 op  in  3  operation code (REQ-010).
REQ-007 in0, in1  in  WIDTH each  operands; in1 is the shift amount for shifts.
REQ-008 out_valid  out  1  result/flags valid; out_ready  in  1  consumer accepts.
REQ-009 result  out  WIDTH; zero, carry, ovf  out  1 each  status flags.

Function
REQ-010 op encoding: 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 OR, 101 SLT, 110 AND, 111 MUL.
REQ-011 States: IDLE, MUL, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 IDLE: in_valid=1 captures op/in0/in1; op≠MUL -> DONE next cycle with result registered (latency 1 cycle from accept to out_valid).
REQ-013 IDLE: in_valid=1 with op=MUL -> MUL; shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (latency WIDTH+1).
REQ-014 DONE: result and flags held stable while out_ready=0; out_valid&out_ready -> IDLE next cycle; no new operation accepted in the same cycle.
REQ-015 in0/in1/op changes after accept do not affect the in-flight operation.
REQ-016 ADD/SUB: modulo 2^WIDTH; carry = carry-out (ADD) or borrow, i.e. in0<in1 unsigned (SUB); ovf = signed two's-complement overflow.
REQ-017 SLL/SRL: logical; shift amount = in1 unsigned; amount ≥ WIDTH gives result 0; carry=ovf=0.
REQ-018 SLT: result = 1 (zero-extended) if in0 < in1 signed, overflow-correct, else 0; carry=ovf=0.
REQ-019 OR/AND: bitwise; carry=ovf=0.
REQ-020 MUL: unsigned; result = low WIDTH bits of product; ovf = 1 iff high WIDTH bits nonzero; carry=0.
REQ-021 zero = 1 iff registered result == 0, all ops.
REQ-022 Multiplier counter counts WIDTH iterations exactly; no wrap beyond; in_valid ignored during MUL.

Reset
REQ-023 reset=1 at any clock edge -> state IDLE, result=0, zero=0, carry=0, ovf=0, out_valid=0, in_ready=1 from the following cycle.
REQ-024 reset during MUL or DONE aborts the operation; no result is ever presented for it.
REQ-025 reset has priority over every handshake in the same cycle.

Structure
REQ-026 Shared package ula_pkg holds op encodings (OP_ADD..OP_MUL) and the state enumeration (ST_IDLE, ST_MUL, ST_DONE).
REQ-027 Iterative multiplier is sub-module ula_mul_seq (start, busy/done, WIDTH-bit operands, 2*WIDTH product); remaining ops are combinational inside ula_seq feeding a registered output stage.
REQ-028 No combinational path from in_valid/in0/in1/op to result or flags.

Verification (WIDTH=16)
REQ-029 ADD 0xFFFF+0x0001 -> after 1 cycle out_valid, result 0x0000, zero=1, carry=1, ovf=0; ADD 0x7FFF+0x0001 -> 0x8000, ovf=1.
REQ-030 SUB 0x0003-0x0005 -> 0xFFFE, carry=1; SLT 0x8000,0x0001 -> 0x0001; SLT 0x7FFF,0x8000 -> 0x0000.
REQ-031 SLL 0x0001 by 15 -> 0x8000; SLL by 16 -> 0x0000, zero=1; SRL 0x8000 by 4 -> 0x0800.
REQ-032 MUL 0x00FF*0x0101 -> out_valid exactly 17 cycles after accept, result 0xFFFF, ovf=0; MUL 0x1000*0x0010 -> 0x0000, zero=1, ovf=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 reset asserted at MUL cycle 8 -> next cycle IDLE, out_valid=0, result=0; following ADD 2+3 -> 0x0005.
